// File: rtl/freq_cal_pkg.sv
// Shared types for the frequency trim calibrator.
package freq_cal_pkg;

   // SAR calibration sequencer states.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETTLE    = 3'd1,
      START     = 3'd2,
      WAIT_ACK  = 3'd3,
      WAIT_DONE = 3'd4,
      DECIDE    = 3'd5,
      FINISH    = 3'd6
   } cal_state_t;

   // Width needed to hold values 0..max_value (never less than 1 bit).
   function automatic int unsigned cnt_width(input int unsigned max_value);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) <= 64'(max_value)) w++;
      return w;
   endfunction

endpackage

// File: rtl/freq_cal_downcounter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module freq_cal_downcounter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   // Load has priority over decrement; the count never wraps below zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/freq_trim_calibrator.sv
// Successive-approximation trim controller driving a frequency comparator.
// One trim bit is decided per measurement, MSB first.
module freq_trim_calibrator
   import freq_cal_pkg::*;
#(
   parameter int unsigned TRIM_WIDTH    = 6,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned WDOG_CYCLES   = 65535
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cal_start,
   input  logic [DATA_WIDTH-1:0] window_value,
   output logic                  cal_busy,
   output logic                  cal_done,
   output logic                  cal_error,
   output logic [TRIM_WIDTH-1:0] trim_code,
   output logic                  meas_enable,
   output logic [DATA_WIDTH-1:0] meas_timeout,
   input  logic                  compare_ge,
   input  logic                  compare_done
);

   localparam int unsigned IDX_W    = cnt_width(TRIM_WIDTH - 1);
   localparam int unsigned SETTLE_W = cnt_width(SETTLE_CYCLES);
   localparam int unsigned WDOG_W   = cnt_width(WDOG_CYCLES);

   cal_state_t            r_state;
   cal_state_t            w_state_next;

   logic [TRIM_WIDTH-1:0] r_trim_code;
   logic [IDX_W-1:0]      r_bit_idx;
   logic [DATA_WIDTH-1:0] r_meas_timeout;
   logic                  r_cal_error;
   logic                  r_ge_q;

   logic                  w_accept;
   logic                  w_settle_load;
   logic                  w_settle_dec;
   logic                  w_settle_zero;
   logic                  w_wdog_load;
   logic                  w_wdog_dec;
   logic                  w_wdog_zero;
   logic                  w_wdog_trip;
   logic                  w_last_bit;
   logic [TRIM_WIDTH-1:0] w_bit_mask;
   logic [TRIM_WIDTH-1:0] w_next_mask;
   logic [TRIM_WIDTH-1:0] w_trim_decided;

   // Settle-time counter, reloaded on every trim change.
   freq_cal_downcounter #(
      .WIDTH (SETTLE_W)
   ) u_settle_cnt (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_settle_load),
      .i_load_value (SETTLE_W'(SETTLE_CYCLES)),
      .i_dec        (w_settle_dec),
      .o_zero       (w_settle_zero)
   );

   // Measurement watchdog, loaded when a measurement is started.
   freq_cal_downcounter #(
      .WIDTH (WDOG_W)
   ) u_wdog_cnt (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_wdog_load),
      .i_load_value (WDOG_W'(WDOG_CYCLES)),
      .i_dec        (w_wdog_dec),
      .o_zero       (w_wdog_zero)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; in WAIT_ACK/WAIT_DONE the comparator event wins over an expiring watchdog.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:      if (cal_start) w_state_next = SETTLE;
         SETTLE:    if (w_settle_zero) w_state_next = START;
         START:     w_state_next = WAIT_ACK;
         WAIT_ACK: begin
            if (!compare_done)    w_state_next = WAIT_DONE;
            else if (w_wdog_zero) w_state_next = IDLE;
         end
         WAIT_DONE: begin
            if (compare_done)     w_state_next = DECIDE;
            else if (w_wdog_zero) w_state_next = IDLE;
         end
         DECIDE:    w_state_next = w_last_bit ? FINISH : SETTLE;
         FINISH:    w_state_next = IDLE;
         default:   w_state_next = IDLE;
      endcase
   end

   // State-decoded outputs and counter controls.
   always_comb begin
      w_accept      = (r_state == IDLE) && cal_start;
      w_last_bit    = (r_bit_idx == '0);
      w_settle_load = w_accept || ((r_state == DECIDE) && !w_last_bit);
      w_settle_dec  = (r_state == SETTLE) && !w_settle_zero;
      w_wdog_load   = (r_state == START);
      w_wdog_dec    = ((r_state == WAIT_ACK) || (r_state == WAIT_DONE)) && !w_wdog_zero;
      w_wdog_trip   = w_wdog_zero &&
                      (((r_state == WAIT_ACK)  &&  compare_done) ||
                       ((r_state == WAIT_DONE) && !compare_done));
      meas_enable   = (r_state == START);
      cal_done      = (r_state == FINISH);
      cal_busy      = (r_state != IDLE) && (r_state != FINISH);
   end

   // Trim bit arithmetic for the DECIDE step.
   always_comb begin
      w_bit_mask     = TRIM_WIDTH'(1) << r_bit_idx;
      w_next_mask    = w_last_bit ? '0 : (TRIM_WIDTH'(1) << (r_bit_idx - IDX_W'(1)));
      w_trim_decided = r_ge_q ? r_trim_code : (r_trim_code & ~w_bit_mask);
   end

   // Datapath registers: trim code, bit index, window, result capture and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_trim_code    <= '0;
         r_bit_idx      <= '0;
         r_meas_timeout <= '0;
         r_cal_error    <= 1'b0;
         r_ge_q         <= 1'b0;
      end else begin
         if (w_accept) begin
            r_trim_code    <= TRIM_WIDTH'(1) << (TRIM_WIDTH - 1);
            r_bit_idx      <= IDX_W'(TRIM_WIDTH - 1);
            r_meas_timeout <= window_value;
            r_cal_error    <= 1'b0;
         end
         if (w_wdog_trip) begin
            r_cal_error <= 1'b1;
         end
         if ((r_state == WAIT_DONE) && compare_done) begin
            r_ge_q <= compare_ge;
         end
         if (r_state == DECIDE) begin
            r_trim_code <= w_trim_decided | w_next_mask;
            if (!w_last_bit) begin
               r_bit_idx <= r_bit_idx - IDX_W'(1);
            end
         end
      end
   end

   assign trim_code    = r_trim_code;
   assign meas_timeout = r_meas_timeout;
   assign cal_error    = r_cal_error;

endmodule
